// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator towards a word-only data memory.
// Sub-word stores are done as read-modify-write of the containing word; loads
// extract a little-endian byte/half lane and extend it. Misaligned requests
// complete with an error and never touch the memory port.
module lsu_mem_master #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  output logic        mem_RE,
  input  logic [31:0] mem_RD
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]    off_r;
  logic [1:0]    size_r;
  logic          signed_r;
  logic          we_r;
  logic [31:0]   wdata_r;

  // Size code 3 behaves exactly like a word access.
  function automatic logic is_word(input logic [1:0] size);
    return (size == 2'd0) || (size == 2'd3);
  endfunction

  // Half needs addr[0]==0, word needs addr[1:0]==0; bytes are always aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      2'd1:    bad = 1'b0;
      2'd2:    bad = off[0];
      default: bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

  // Insert the store lane into the word read back from memory.
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] wd,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] ins;
    sh = {off, 3'b000};
    case (size)
      2'd1: begin
        mask = 32'h0000_00FF << sh;
        ins  = {24'h00_0000, wd[7:0]} << sh;
      end
      2'd2: begin
        mask = 32'h0000_FFFF << {off[1], 4'b0000};
        ins  = {16'h0000, wd[15:0]} << {off[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        ins  = wd;
      end
    endcase
    return (old_word & ~mask) | (ins & mask);
  endfunction

  // Pull the addressed lane out of the read word and extend it.
  function automatic logic [31:0] extract_load(input logic [31:0] rd,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sgn);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = rd >> {off, 3'b000};
    case (size)
      2'd1:    res = sgn ? {{24{shifted[7]}}, shifted[7:0]}   : {24'h00_0000, shifted[7:0]};
      2'd2:    res = sgn ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0000, shifted[15:0]};
      default: res = rd;
    endcase
    return res;
  endfunction

  // Request FSM; every port output is a register updated on state transitions.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      off_r      <= 2'b00;
      size_r     <= 2'b00;
      signed_r   <= 1'b0;
      we_r       <= 1'b0;
      wdata_r    <= 32'h0000_0000;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      mem_A      <= 32'h0000_0000;
      mem_WD     <= 32'h0000_0000;
      mem_WE     <= 1'b0;
      mem_RE     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            off_r     <= req_addr[1:0];
            size_r    <= req_size;
            signed_r  <= req_signed;
            we_r      <= req_we;
            wdata_r   <= req_wdata;
            req_ready <= 1'b0;
            if (misaligned(req_size, req_addr[1:0])) begin
              state_r    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0000_0000;
            end else begin
              mem_A <= {req_addr[31:2], 2'b00};
              if (req_we && is_word(req_size)) begin
                state_r <= WR;
                mem_WE  <= 1'b1;
                mem_WD  <= req_wdata;
              end else begin
                state_r <= RD_WAIT;
                mem_RE  <= 1'b1;
                cnt_r   <= '0;
              end
            end
          end
        end
        RD_WAIT: begin
          if (cnt_r == CW'(RD_LAT - 1)) begin
            mem_RE <= 1'b0;
            if (we_r) begin
              state_r <= WR;
              mem_WE  <= 1'b1;
              mem_WD  <= merge_word(mem_RD, wdata_r, size_r, off_r);
            end else begin
              state_r    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= extract_load(mem_RD, size_r, off_r, signed_r);
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        WR: begin
          mem_WE     <= 1'b0;
          state_r    <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
        end
        RESP: begin
          state_r    <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
          req_ready  <= 1'b1;
        end
        default: begin
          state_r    <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
          mem_WE     <= 1'b0;
          mem_RE     <= 1'b0;
        end
      endcase
    end
  end

endmodule
